// File: rtl/sbox_sched_if.sv
// Bundle between the S-box requesters / shared ROM and the sbox_sched arbiter.
// Latency: none (wires only).
// Backpressure: req_ready is the only stall; responses and ROM reads are never stalled.
//
// master: requester lanes plus the ROM data return (drives req_*, sbox_y)
// slave : the scheduler (drives req_ready, rsp_*, sbox_a, busy)
interface sbox_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_byte;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [8*NREQ-1:0] rsp_byte;
    logic [7:0]        sbox_a;
    logic [7:0]        sbox_y;
    logic              busy;

    modport master (
        output req_valid, req_byte, sbox_y,
        input  req_ready, rsp_valid, rsp_byte, sbox_a, busy
    );

    modport slave (
        input  req_valid, req_byte, sbox_y,
        output req_ready, rsp_valid, rsp_byte, sbox_a, busy
    );
endinterface

// File: rtl/sbox_sched.sv
// Round-robin time-sharing of one synchronous S-box ROM among NREQ requesters.
// Latency: grant in cycle t -> rsp_valid/rsp_byte in cycle t+1, one lookup per cycle, no bubbles.
// Backpressure: one-hot combinational req_ready per cycle; responses cannot be stalled.
//
// Ports: clk, reset (sync, active-high), bus (sbox_sched_if.slave):
//   req_valid/req_byte/req_ready  requester handshake, byte k in bits [8k+7:8k]
//   rsp_valid/rsp_byte            one-hot result return, unselected lanes read 8'h00
//   sbox_a/sbox_y                 shared ROM address out / registered ROM data in
//   busy                          a lookup is in flight
// Optional macro SBOX_SCHED_PRIO_EN: lane 0 (key expansion) gets absolute priority,
// lanes 1..NREQ-1 round-robin among themselves.
module sbox_sched #(
    parameter int NREQ = 4
) (
    input  logic         clk,
    input  logic         reset,
    sbox_sched_if.slave  bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef SBOX_SCHED_PRIO_EN
    localparam logic [PW-1:0] PTR_RST = PW'(1);
`else
    localparam logic [PW-1:0] PTR_RST = '0;
`endif

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt;
    logic            tag_valid;
    logic [PW-1:0]   tag_id;
    logic            gnt_any;
    logic [PW-1:0]   gnt_id;
    logic [NREQ-1:0] gnt_oh;

    // Arbitration: scan lanes starting at ptr, first valid one wins.
    always_comb begin
        int            lane;
        logic [PW-1:0] cand;
        lane    = 0;
        cand    = '0;
        gnt_any = 1'b0;
        gnt_id  = '0;
`ifdef SBOX_SCHED_PRIO_EN
        if (bus.req_valid[0]) begin
            gnt_any = 1'b1;
            gnt_id  = '0;
        end else begin
            // ptr lives in 1..NREQ-1, so wrap back to lane 1, never lane 0
            for (int i = 0; i < NREQ - 1; i++) begin
                lane = int'(ptr) + i;
                if (lane >= NREQ) lane = lane - (NREQ - 1);
                cand = PW'(lane);
                if (!gnt_any && bus.req_valid[cand]) begin
                    gnt_any = 1'b1;
                    gnt_id  = cand;
                end
            end
        end
`else
        for (int i = 0; i < NREQ; i++) begin
            lane = int'(ptr) + i;
            if (lane >= NREQ) lane = lane - NREQ;
            cand = PW'(lane);
            if (!gnt_any && bus.req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_id  = cand;
            end
        end
`endif
        // No grants while reset is held, so the ROM sees 8'h00 and nobody
        // believes a transfer happened.
        if (reset) begin
            gnt_any = 1'b0;
            gnt_id  = '0;
        end
    end

    // Pointer advance past the granted lane.
    always_comb begin
        ptr_nxt = ptr;
`ifdef SBOX_SCHED_PRIO_EN
        // Lane-0 grants leave the rotation among lanes 1..NREQ-1 untouched
        if (gnt_any && gnt_id != '0) begin
            if (gnt_id == PW'(NREQ - 1)) ptr_nxt = PW'(1);
            else                         ptr_nxt = gnt_id + PW'(1);
        end
`else
        if (gnt_any) begin
            if (gnt_id == PW'(NREQ - 1)) ptr_nxt = '0;
            else                         ptr_nxt = gnt_id + PW'(1);
        end
`endif
    end

    always_comb begin
        gnt_oh = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_any && gnt_id == PW'(k)) gnt_oh[k] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= PTR_RST;
            tag_valid <= 1'b0;
            tag_id    <= '0;
        end else begin
            ptr       <= ptr_nxt;
            tag_valid <= gnt_any;
            tag_id    <= gnt_id;
        end
    end

    assign bus.req_ready = gnt_oh;
    assign bus.busy      = tag_valid;

    // ROM address: the granted lane's byte, or 8'h00 when idle.
    always_comb begin
        bus.sbox_a = 8'h00;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_oh[k]) bus.sbox_a = bus.req_byte[8*k +: 8];
        end
    end

    // ROM data arrives one cycle after the address; steer it by the tag that
    // was captured alongside that address.
    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_byte  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (tag_valid && tag_id == PW'(k)) begin
                bus.rsp_valid[k]        = 1'b1;
                bus.rsp_byte[8*k +: 8]  = bus.sbox_y;
            end
        end
    end

endmodule

// File: tb/tb_sbox_sched.sv
module tb_sbox_sched;

    localparam int NREQ = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sbox_sched_if #(.NREQ(NREQ)) bus ();

    sbox_sched #(.NREQ(NREQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // AES S-box entries used by the directed vectors
    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        case (a)
            8'h00:   sbox_ref = 8'h63;
            8'h01:   sbox_ref = 8'h7C;
            8'h10:   sbox_ref = 8'hCA;
            8'hFF:   sbox_ref = 8'h16;
            8'h53:   sbox_ref = 8'hED;
            default: sbox_ref = 8'h00;
        endcase
    endfunction

    // Shared synchronous ROM: one-cycle read latency
    always @(posedge clk) bus.sbox_y <= sbox_ref(bus.sbox_a);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic logic [31:0] lane_val(input int k, input logic [7:0] v);
        logic [31:0] t;
        t = {24'h0, v};
        lane_val = t << (8 * k);
    endfunction

    logic [7:0] cb [4] = '{8'h00, 8'h01, 8'h10, 8'hFF};
    logic [7:0] cs [4] = '{8'h63, 8'h7C, 8'hCA, 8'h16};
    logic [7:0] bb [3] = '{8'h00, 8'h01, 8'hFF};
    logic [7:0] bs [3] = '{8'h63, 8'h7C, 8'h16};

    initial begin
        bus.req_valid = '0;
        bus.req_byte  = '0;
        repeat (3) @(posedge clk);
        #1;

        // During reset: requests must not be granted
        bus.req_valid = 4'b1111;
        bus.req_byte  = 32'hFF100153;
        smp();
        chk("rst_ready",  bus.req_ready, 4'b0000);
        chk("rst_sbox_a", bus.sbox_a,    8'h00);
        chk("rst_rspv",   bus.rsp_valid, 4'b0000);
        chk("rst_rspb",   bus.rsp_byte,  32'h0);
        chk("rst_busy",   bus.busy,      1'b0);
        tick();

        // Single lookup on lane 0
        reset         = 1'b0;
        bus.req_valid = 4'b0001;
        bus.req_byte  = 32'h00000053;
        smp();
        chk("single_ready",  bus.req_ready, 4'b0001);
        chk("single_sbox_a", bus.sbox_a,    8'h53);
        tick();
        bus.req_valid = '0;
        smp();
        chk("single_rspv", bus.rsp_valid, 4'b0001);
        chk("single_rspb", bus.rsp_byte,  32'h000000ED);
        chk("single_busy", bus.busy,      1'b1);
        tick();
        smp();
        chk("single_idle_rspv", bus.rsp_valid, 4'b0000);
        chk("single_idle_busy", bus.busy,      1'b0);

        // Fresh reset so ptr starts from its reset value
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;

`ifdef SBOX_SCHED_PRIO_EN
        bus.req_valid = 4'b1111;
        bus.req_byte  = 32'hFF100100;
        for (int c = 0; c < 4; c++) begin
            smp();
            chk("prio_l0_ready", bus.req_ready, 4'b0001);
            chk("prio_l0_sbox_a", bus.sbox_a, 8'h00);
            if (c > 0) chk("prio_l0_rspb", bus.rsp_byte, 32'h00000063);
            tick();
        end
        bus.req_valid = 4'b1110;
        for (int c = 0; c < 4; c++) begin
            logic [3:0] e;
            e = (c == 0) ? 4'b0010 : (c == 1) ? 4'b0100 : (c == 2) ? 4'b1000 : 4'b0010;
            smp();
            chk("prio_rr_ready", bus.req_ready, e);
            if (c == 0) chk("prio_rr_rspb0", bus.rsp_byte, 32'h00000063);
            tick();
        end
        bus.req_valid = '0;
`else
        // Full contention: grants rotate 0,1,2,3,0,...
        bus.req_valid = 4'b1111;
        bus.req_byte  = 32'hFF100100;
        for (int c = 0; c < 8; c++) begin
            smp();
            chk("full_ready",  bus.req_ready, 4'b0001 << (c % 4));
            chk("full_sbox_a", bus.sbox_a,    cb[c % 4]);
            if (c > 0) begin
                chk("full_rspv", bus.rsp_valid, 4'b0001 << ((c - 1) % 4));
                chk("full_rspb", bus.rsp_byte,  lane_val((c - 1) % 4, cs[(c - 1) % 4]));
            end
            tick();
        end

        // Last grant was lane 3 -> ptr wraps to 0 and holds while idle
        bus.req_valid = '0;
        smp();
        chk("wrap_rspb",  bus.rsp_byte,  32'h16000000);
        chk("wrap_ready", bus.req_ready, 4'b0000);
        tick();
        smp();
        chk("wrap_idle_rspv", bus.rsp_valid, 4'b0000);
        chk("wrap_idle_busy", bus.busy,      1'b0);
        tick();
        bus.req_valid = 4'b0110;
        smp();
        chk("hold_ready1",  bus.req_ready, 4'b0010);
        chk("hold_sbox_a1", bus.sbox_a,    8'h01);
        tick();
        smp();
        chk("hold_ready2",  bus.req_ready, 4'b0100);
        chk("hold_sbox_a2", bus.sbox_a,    8'h10);
        chk("hold_rspb1",   bus.rsp_byte,  32'h00007C00);
        tick();
        bus.req_valid = '0;
        smp();
        chk("hold_rspv2", bus.rsp_valid, 4'b0100);
        chk("hold_rspb2", bus.rsp_byte,  32'h00CA0000);
        tick();

        // Back-to-back lookups on lane 2
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                bus.req_valid = 4'b0100;
                bus.req_byte  = lane_val(2, bb[i]);
            end else begin
                bus.req_valid = '0;
            end
            smp();
            if (i < 3) chk("b2b_ready", bus.req_ready, 4'b0100);
            if (i > 0) begin
                chk("b2b_rspv", bus.rsp_valid, 4'b0100);
                chk("b2b_rspb", bus.rsp_byte,  lane_val(2, bs[i - 1]));
            end
            tick();
        end

        // Reset while a lane-1 lookup is being granted
        bus.req_valid = 4'b0010;
        bus.req_byte  = 32'h00005300;
        smp();
        chk("mid_ready", bus.req_ready, 4'b0010);
        reset = 1'b1;
        tick();
        reset         = 1'b0;
        bus.req_valid = '0;
        smp();
        chk("mid_rspv", bus.rsp_valid, 4'b0000);
        chk("mid_rspb", bus.rsp_byte,  32'h0);
        chk("mid_busy", bus.busy,      1'b0);
        tick();
        bus.req_valid = 4'b1111;
        bus.req_byte  = 32'hFF100100;
        smp();
        chk("mid_ptr0_ready", bus.req_ready, 4'b0001);
        chk("mid_rspv2",      bus.rsp_valid, 4'b0000);
        tick();
        bus.req_valid = '0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sbox_sched.md
# sbox_sched

Round-robin scheduler that time-shares one synchronous S-box ROM (one-cycle read latency, block-RAM mapped) among NREQ requesters, e.g. SubBytes byte lanes and the key-expansion SubWord path. It grants at most one lookup per cycle, drives the shared ROM address, and routes the registered ROM output back to the granted requester one cycle later. It sits between the AES round/key-schedule controllers and the single shared sbox_sync instance.

## Interface
- NREQ, 4: number of requesters (2..8).
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  requester k has a byte to substitute.
- req_byte  in  8*NREQ  byte for requester k in bits [8k+7:8k].
- req_ready  out  NREQ  one-hot grant, combinational, same cycle as req_valid.
- rsp_valid  out  NREQ  one-hot; requester k's result is on rsp_byte this cycle.
- rsp_byte  out  8*NREQ  substituted byte in lane k when rsp_valid[k], else 8'h00.
- sbox_a  out  8  address to the shared ROM.
- sbox_y  in  8  ROM output, valid the cycle after sbox_a is presented.
- busy  out  1  a lookup is in flight (tag register valid).

## Operation
- Handshake: a transfer on lane k happens in a cycle when req_valid[k] && req_ready[k]. req_ready is asserted on at most one lane per cycle and never on a lane with req_valid low.
- Arbitration: a round-robin pointer ptr (clog2(NREQ) bits) names the highest-priority lane. The grant goes to the first valid lane at or after ptr, wrapping modulo NREQ. After a grant to lane g, ptr <= (g+1) mod NREQ. With no grant, ptr holds.
- Address: sbox_a = req_byte lane of the granted requester. With no grant, sbox_a = 8'h00 (ROM read is harmless).
- Tag pipeline: tag_valid <= grant_any and tag_id <= g at every posedge. Next cycle, rsp_valid = onehot(tag_id) when tag_valid, and rsp_byte lane tag_id = sbox_y.
- Responses have no backpressure. Requesters must sample rsp in the cycle rsp_valid is high.
- A requester may hold req_valid across cycles. Each granted cycle is a new, independent lookup, so back-to-back lookups on one lane are allowed.
- busy = tag_valid.

## Timing
- Reset values:
  - ptr=0, tag_valid=0, tag_id=0.
  - rsp_valid=0, rsp_byte=0, busy=0.
  - req_ready and sbox_a are combinational and follow the inputs from the first cycle after reset deasserts. During reset, req_ready=0 and sbox_a=8'h00.
- Latency: grant in cycle t gives rsp_valid in cycle t+1. There are no bubbles.
- Throughput: one lookup per cycle in aggregate. Under full contention, each lane is granted at least once every NREQ cycles.
- Simultaneous events: a new grant in cycle t+1 and the response for the cycle-t grant coexist. They use independent tag and address paths.
- Reset mid-operation: an in-flight lookup is discarded. No rsp_valid appears in the cycle after reset is sampled high, and ptr returns to 0.
- Single requester: when only lane k is valid, it is granted every cycle, regardless of ptr.

## Configuration
- SBOX_SCHED_PRIO_EN defined:
  - Lane 0 (key expansion) wins whenever req_valid[0]=1, and ptr is not updated by lane-0 grants.
  - Lanes 1..NREQ-1 round-robin among themselves, with ptr ranging 1..NREQ-1 and wrapping from NREQ-1 to 1.
  - Reset ptr=1.
- SBOX_SCHED_PRIO_EN undefined: pure round-robin over all lanes as described above.

## Test plan
- Reset, then single lookup: req_valid=4'b0001, lane0=8'h53 for one cycle -> req_ready=4'b0001 that cycle; next cycle rsp_valid=4'b0001, rsp lane0=8'hED, other lanes 8'h00, busy=1.
- Full contention from reset with lanes 0..3 = 8'h00, 8'h01, 8'h10, 8'hFF held valid -> grants 0,1,2,3,0,...; responses one cycle later are 8'h63, 8'h7C, 8'hCA, 8'h16 on the matching lanes.
- Wrap and pointer hold: grant lane 3, drop all valids for 2 cycles, then raise lanes 1 and 2 -> lane 1 is granted first, because ptr=0 was held and lane 0 is idle.
- Back-to-back single lane: lane 2 valid for 3 cycles with 8'h00, 8'h01, 8'hFF -> rsp_valid[2] high for 3 consecutive cycles carrying 8'h63, 8'h7C, 8'h16.
- Reset mid-flight: grant lane 1 (8'h53) and assert reset the same next edge -> no rsp_valid in the following cycles, ptr=0, busy=0.
- With SBOX_SCHED_PRIO_EN and all lanes valid for 4 cycles -> lane 0 granted every cycle. Then drop lane 0 -> grants 1,2,3,1.
